// File: rtl/lcd_uc1611_rx.sv
// UC1611-style LCD bus receiver: decodes command bytes into control registers and turns data bytes into framebuffer writes.
// Latency: an accepted data byte appears as an fb_we pulse on the following cycle; commands take effect on the next edge.
// Backpressure: none; every accepted byte is consumed. Optional mirroring is selected by macro LCD_UC1611_RX_MIRROR_EN.
module lcd_uc1611_rx #(
  parameter int COLS  = 160,
  parameter int PAGES = 80
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  lcd_data,
  input  logic        lcd_write,
  input  logic        lcd_cs,
  input  logic        lcd_read,
  input  logic        lcd_cd,
  output logic        fb_we,
  output logic [14:0] fb_addr,
  output logic [7:0]  fb_data,
  output logic [2:0]  disp_en,
  output logic [2:0]  ac,
  output logic [1:0]  gray,
  output logic        map_my,
  output logic        map_mx,
  output logic        map_msf,
  output logic [7:0]  scroll,
  output logic [7:0]  pm,
  output logic        sys_rst
);

  logic [7:0]  col_q, col_d, col_nxt;
  logic [6:0]  page_q, page_d, page_nxt;
  logic [2:0]  ac_q, ac_d;
  logic [2:0]  disp_en_q, disp_en_d;
  logic [2:0]  map_q, map_d;            // {my, mx, msf}
  logic [1:0]  gray_q, gray_d;
  logic [7:0]  scroll_q, scroll_d;
  logic [7:0]  pm_q, pm_d;
  logic        pm_pend_q, pm_pend_d;
  logic        fb_we_q, fb_we_d;
  logic [14:0] fb_addr_q, fb_addr_d;
  logic [7:0]  fb_data_q, fb_data_d;
  logic        sys_rst_q, sys_rst_d;

  logic        accept;
  logic        in_range;
  logic [7:0]  col_map;
  logic [6:0]  page_map;
  logic [14:0] addr_map;

  assign accept   = lcd_write & lcd_cs & ~lcd_read;
  assign in_range = ({1'b0, page_q} < 8'(PAGES)) && ({1'b0, col_q} < 9'(COLS));

`ifdef LCD_UC1611_RX_MIRROR_EN
  assign col_map  = map_q[1] ? (8'(COLS - 1) - col_q) : col_q;
  assign page_map = map_q[2] ? (7'(PAGES - 1) - page_q) : page_q;
`else
  assign col_map  = col_q;
  assign page_map = page_q;
`endif

  // Product fits in 15 bits for the largest legal geometry (128*256-1).
  assign addr_map = 15'(page_map) * 15'(COLS) + 15'(col_map);

  // Address auto-increment: column-first or page-first, page direction from ac[2], wrap or hold at the end.
  always_comb begin
    logic       col_last, page_last;
    logic [6:0] page_first, page_step;
    col_nxt    = col_q;
    page_nxt   = page_q;
    col_last   = (col_q == 8'(COLS - 1));
    page_last  = ac_q[2] ? (page_q == 7'd0) : (page_q == 7'(PAGES - 1));
    page_first = ac_q[2] ? 7'(PAGES - 1) : 7'd0;
    page_step  = ac_q[2] ? (page_q - 7'd1) : (page_q + 7'd1);
    if (col_last && page_last) begin
      if (ac_q[0]) begin
        col_nxt  = 8'd0;
        page_nxt = page_first;
      end
    end else if (!ac_q[1]) begin
      if (col_last) begin
        col_nxt  = 8'd0;
        page_nxt = page_step;
      end else begin
        col_nxt = col_q + 8'd1;
      end
    end else begin
      if (page_last) begin
        page_nxt = page_first;
        col_nxt  = col_q + 8'd1;
      end else begin
        page_nxt = page_step;
      end
    end
  end

  // Byte decode: command register updates, pm capture, pixel writes and the soft reset.
  always_comb begin
    col_d     = col_q;
    page_d    = page_q;
    ac_d      = ac_q;
    disp_en_d = disp_en_q;
    map_d     = map_q;
    gray_d    = gray_q;
    scroll_d  = scroll_q;
    pm_d      = pm_q;
    pm_pend_d = pm_pend_q;
    fb_we_d   = 1'b0;
    fb_addr_d = fb_addr_q;
    fb_data_d = fb_data_q;
    sys_rst_d = 1'b0;
    if (accept) begin
      if (!lcd_cd) begin
        if (pm_pend_q) begin
          // The byte after 0x81 is always the gain value, never decoded.
          pm_d      = lcd_data;
          pm_pend_d = 1'b0;
        end else begin
          casez (lcd_data)
            8'b0000_????: col_d[3:0]    = lcd_data[3:0];
            8'b0001_????: col_d[7:4]    = lcd_data[3:0];
            8'b0100_????: scroll_d[3:0] = lcd_data[3:0];
            8'b0101_????: scroll_d[7:4] = lcd_data[3:0];
            8'b0110_????: page_d[3:0]   = lcd_data[3:0];
            8'b0111_0???: page_d[6:4]   = lcd_data[2:0];
            8'b1000_1???: ac_d          = lcd_data[2:0];
            8'b1010_1???: disp_en_d     = lcd_data[2:0];
            8'b1100_0???: map_d         = lcd_data[2:0];
            8'b1101_00??: gray_d        = lcd_data[1:0];
            8'h81:        pm_pend_d     = 1'b1;
            8'hE2: begin
              col_d     = 8'd0;
              page_d    = 7'd0;
              ac_d      = 3'b001;
              disp_en_d = 3'd0;
              map_d     = 3'd0;
              gray_d    = 2'd0;
              scroll_d  = 8'd0;
              pm_d      = 8'd0;
              pm_pend_d = 1'b0;
              fb_addr_d = 15'd0;
              fb_data_d = 8'd0;
              sys_rst_d = 1'b1;
            end
            default: ;
          endcase
        end
      end else begin
        pm_pend_d = 1'b0;
        if (in_range) begin
          fb_we_d   = 1'b1;
          fb_addr_d = addr_map;
          fb_data_d = lcd_data;
          col_d     = col_nxt;
          page_d    = page_nxt;
        end
      end
    end
  end

  // State registers with synchronous active-low reset; a byte seen during reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      col_q     <= 8'd0;
      page_q    <= 7'd0;
      ac_q      <= 3'b001;
      disp_en_q <= 3'd0;
      map_q     <= 3'd0;
      gray_q    <= 2'd0;
      scroll_q  <= 8'd0;
      pm_q      <= 8'd0;
      pm_pend_q <= 1'b0;
      fb_we_q   <= 1'b0;
      fb_addr_q <= 15'd0;
      fb_data_q <= 8'd0;
      sys_rst_q <= 1'b0;
    end else begin
      col_q     <= col_d;
      page_q    <= page_d;
      ac_q      <= ac_d;
      disp_en_q <= disp_en_d;
      map_q     <= map_d;
      gray_q    <= gray_d;
      scroll_q  <= scroll_d;
      pm_q      <= pm_d;
      pm_pend_q <= pm_pend_d;
      fb_we_q   <= fb_we_d;
      fb_addr_q <= fb_addr_d;
      fb_data_q <= fb_data_d;
      sys_rst_q <= sys_rst_d;
    end
  end

  assign fb_we   = fb_we_q;
  assign fb_addr = fb_addr_q;
  assign fb_data = fb_data_q;
  assign disp_en = disp_en_q;
  assign ac      = ac_q;
  assign gray    = gray_q;
  assign map_my  = map_q[2];
  assign map_mx  = map_q[1];
  assign map_msf = map_q[0];
  assign scroll  = scroll_q;
  assign pm      = pm_q;
  assign sys_rst = sys_rst_q;

endmodule
